clk_nonoverlap_monitor: RTL
===========================

# clk_nonoverlap_monitor

Receive-side checker for the non-overlapping clock generator outputs: samples the modulated clock pair (MOD, MODN) in the USER_CLOCK domain and measures them over a fixed window. Per window it reports rising-edge counts, MOD high-time and MOD/MODN overlap. Results are presented through a valid/ack handshake to the host or readout logic. Sits after the selected-frequency clock path; closes the loop on frequency, duty and phase selection.

## Interface
- WINDOW_CYCLES, 1000: USER_CLOCK cycles per measurement window (≥ 4).
- CNT_W, 16: width of every result counter.
- SYNC_STAGES, 2: synchronizer depth per input (≥ 2).
- USER_CLOCK  in  1  sampling/system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run windows while high.
- CLK_MOD_IN  in  1  monitored clock, asynchronous.
- CLK_MODN_IN  in  1  complementary monitored clock, asynchronous.
- MEAS_ACK  in  1  consumer accepts the current result.
- MEAS_VALID  out  1  result registers hold an unacknowledged result.
- EDGE_CNT  out  CNT_W  MOD rising edges in the window.
- EDGEN_CNT  out  CNT_W  MODN rising edges in the window.
- HIGH_CNT  out  CNT_W  cycles with synchronized MOD high.
- OVERLAP_CNT  out  CNT_W  cycles with synchronized MOD and MODN both high.
- OVERRUN  out  1  sticky: a window completed while MEAS_VALID was high.

## Operation
- Each input passes through a SYNC_STAGES flop chain, then one extra flop for edge detection; rise = sync & ~prev.
- FSM: IDLE → ARM on ENABLE; ARM waits SYNC_STAGES+1 cycles (flushes stale samples, no counting) → RUN; RUN → IDLE when ENABLE low (accumulators discarded, no capture).
- RUN: window counter counts 0..WINDOW_CYCLES-1; accumulators update every cycle, saturate at 2^CNT_W-1.
- Terminal cycle: that cycle's contribution included; if MEAS_VALID low or MEAS_ACK high the same cycle, accumulators copy to output registers and MEAS_VALID sets; otherwise result dropped, OVERRUN sets. Accumulators and window counter clear; next window begins without a gap.
- MEAS_ACK with MEAS_VALID high clears MEAS_VALID next cycle and clears OVERRUN; ACK with VALID low ignored.
- Output registers hold until next capture; they are not cleared by ACK or ENABLE low.
- Reset: all outputs 0, FSM IDLE, synchronizers 0.

## Timing
- Input transition to counted event: SYNC_STAGES+1 cycles.
- MEAS_VALID rises the cycle after the window's terminal cycle; outputs are stable whenever VALID high.
- Capture and ACK in the same cycle: new result loaded, MEAS_VALID stays high, no OVERRUN.
- ENABLE low during RUN takes effect next cycle; pending MEAS_VALID unaffected.
- Reset asserted mid-window: immediate clear; no partial result emitted after release.
- Measurable input frequency < USER_CLOCK/2; higher rates alias (not flagged).

## Configuration
- CLK_MON_OVERLAP_CHECK_EN defined: MODN path, EDGEN_CNT and OVERLAP_CNT implemented as above.
- Undefined: CLK_MODN_IN unused, EDGEN_CNT and OVERLAP_CNT constant 0, its synchronizer and accumulators removed; all else unchanged.

## Structure
- Shared package: FSM state enum (IDLE, ARM, RUN), default WINDOW_CYCLES/CNT_W/SYNC_STAGES constants.
- One sub-module: clk_mon_sync_edge (synchronizer + edge detect, outputs level and rise), instantiated per input.

## Test plan
- 10 MHz-equivalent MOD (5 high / 5 low USER_CLOCK cycles), MODN inverted with 1-cycle dead band, ACK each result -> EDGE_CNT 100±1, EDGEN_CNT 100±1, HIGH_CNT 500±5, OVERLAP_CNT 0, OVERRUN 0.
- MOD and MODN driven identical 50% at period 4 -> OVERLAP_CNT = HIGH_CNT ≈ 500; macro undefined -> OVERLAP_CNT 0.
- Never ACK for two windows -> MEAS_VALID held, outputs unchanged, OVERRUN 1 after second window; single ACK -> VALID 0, OVERRUN 0 next cycle.
- ACK asserted on a terminal cycle -> new values loaded, VALID continuously high, OVERRUN 0.
- CNT_W 8, MOD constant high -> HIGH_CNT saturates at 255, EDGE_CNT ≤ 1.
- RESET_N pulsed low at window cycle 500 -> all outputs 0 immediately; first VALID after release at ARM + WINDOW_CYCLES + 1 cycles.

Source files
------------

// File: rtl/clk_nonoverlap_monitor_pkg.sv
// Shared types and default sizing for the non-overlapping clock monitor.
package clk_nonoverlap_monitor_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StArm,
      StRun
   } mon_state_e;

   localparam int unsigned DefWindowCycles = 1000;
   localparam int unsigned DefCntW         = 16;
   localparam int unsigned DefSyncStages   = 2;

endpackage

// File: rtl/clk_nonoverlap_monitor_if.sv
// Result bundle of the clock monitor: valid/ack handshake plus the four window counters.
interface clk_nonoverlap_monitor_if
   import clk_nonoverlap_monitor_pkg::*;
#(
   parameter int unsigned CNT_W = DefCntW
);

   logic             meas_valid;
   logic             meas_ack;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] edgen_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] overlap_cnt;
   logic             overrun;

   modport master (
      output meas_valid,
      output edge_cnt,
      output edgen_cnt,
      output high_cnt,
      output overlap_cnt,
      output overrun,
      input  meas_ack
   );

   modport slave (
      input  meas_valid,
      input  edge_cnt,
      input  edgen_cnt,
      input  high_cnt,
      input  overlap_cnt,
      input  overrun,
      output meas_ack
   );

endinterface

// File: rtl/clk_mon_sync_edge.sv
// Multi-stage synchronizer for an asynchronous clock input, plus a rising-edge detector.
module clk_mon_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/clk_nonoverlap_monitor.sv
// Windowed edge/high-time/overlap monitor for the MOD/MODN clock pair.
// Define CLK_MON_OVERLAP_CHECK_EN to build the MODN path, EDGEN_CNT and OVERLAP_CNT.
module clk_nonoverlap_monitor
   import clk_nonoverlap_monitor_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES = DefWindowCycles,
   parameter int unsigned CNT_W         = DefCntW,
   parameter int unsigned SYNC_STAGES   = DefSyncStages
) (
   input  logic                     i_user_clock,
   input  logic                     i_reset_n,
   input  logic                     i_enable,
   input  logic                     i_clk_mod,
   input  logic                     i_clk_modn,
   clk_nonoverlap_monitor_if.master meas_if
);

   localparam int unsigned WinW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned ArmW = $clog2(SYNC_STAGES + 1);
   localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYCLES - 1);
   localparam logic [ArmW-1:0] ArmLast = ArmW'(SYNC_STAGES);

   mon_state_e r_state;
   mon_state_e w_state_nxt;

   logic [ArmW-1:0]  r_arm_cnt;
   logic [WinW-1:0]  r_win_cnt;
   logic             w_in_arm;
   logic             w_in_run;
   logic             w_terminal;
   logic             w_capture;
   logic             w_ack_hit;
   logic             w_mod_level;
   logic             w_mod_rise;
   logic [CNT_W-1:0] r_edge_acc;
   logic [CNT_W-1:0] r_high_acc;
   logic [CNT_W-1:0] w_edge_nxt;
   logic [CNT_W-1:0] w_high_nxt;
   logic [CNT_W-1:0] r_edge_out;
   logic [CNT_W-1:0] r_high_out;
   logic             r_valid;
   logic             r_overrun;
   logic             w_valid_nxt;
   logic             w_overrun_nxt;

   clk_mon_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_mod (
      .i_clk   (i_user_clock),
      .i_rst_n (i_reset_n),
      .i_async (i_clk_mod),
      .o_level (w_mod_level),
      .o_rise  (w_mod_rise)
   );

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_enable) w_state_nxt = StArm;
         end
         StArm: begin
            if (!i_enable) begin
               w_state_nxt = StIdle;
            end else if (r_arm_cnt == ArmLast) begin
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            if (!i_enable) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_in_arm = (r_state == StArm);
      w_in_run = (r_state == StRun);
   end

   // ARM lasts SYNC_STAGES+1 cycles so stale synchronizer and edge-detect state is flushed.
   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_arm_cnt <= '0;
      end else if (w_in_arm) begin
         r_arm_cnt <= r_arm_cnt + ArmW'(1);
      end else begin
         r_arm_cnt <= '0;
      end
   end

   assign w_terminal = w_in_run && (r_win_cnt == WinLast);
   assign w_ack_hit  = meas_if.meas_ack && r_valid;
   assign w_capture  = w_terminal && (!r_valid || meas_if.meas_ack);

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_win_cnt <= '0;
      end else if (w_in_run && !w_terminal) begin
         r_win_cnt <= r_win_cnt + WinW'(1);
      end else begin
         r_win_cnt <= '0;
      end
   end

   // Saturating accumulators; the terminal cycle's own contribution is part of the result.
   always_comb begin
      w_edge_nxt = r_edge_acc;
      w_high_nxt = r_high_acc;
      if (w_mod_rise && (r_edge_acc != '1)) w_edge_nxt = r_edge_acc + CNT_W'(1);
      if (w_mod_level && (r_high_acc != '1)) w_high_nxt = r_high_acc + CNT_W'(1);
   end

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_edge_acc <= '0;
         r_high_acc <= '0;
      end else if (!w_in_run || w_terminal) begin
         r_edge_acc <= '0;
         r_high_acc <= '0;
      end else begin
         r_edge_acc <= w_edge_nxt;
         r_high_acc <= w_high_nxt;
      end
   end

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_edge_out <= '0;
         r_high_out <= '0;
      end else if (w_capture) begin
         r_edge_out <= w_edge_nxt;
         r_high_out <= w_high_nxt;
      end
   end

   // A dropped window cannot coincide with an ack, so set and clear of OVERRUN never collide.
   always_comb begin
      w_valid_nxt   = r_valid;
      w_overrun_nxt = r_overrun;
      if (w_capture) begin
         w_valid_nxt = 1'b1;
      end else if (w_ack_hit) begin
         w_valid_nxt = 1'b0;
      end
      if (w_terminal && !w_capture) begin
         w_overrun_nxt = 1'b1;
      end else if (w_ack_hit) begin
         w_overrun_nxt = 1'b0;
      end
   end

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid   <= w_valid_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   assign meas_if.meas_valid = r_valid;
   assign meas_if.overrun    = r_overrun;
   assign meas_if.edge_cnt   = r_edge_out;
   assign meas_if.high_cnt   = r_high_out;

`ifdef CLK_MON_OVERLAP_CHECK_EN
   logic             w_modn_level;
   logic             w_modn_rise;
   logic [CNT_W-1:0] r_edgen_acc;
   logic [CNT_W-1:0] r_overlap_acc;
   logic [CNT_W-1:0] w_edgen_nxt;
   logic [CNT_W-1:0] w_overlap_nxt;
   logic [CNT_W-1:0] r_edgen_out;
   logic [CNT_W-1:0] r_overlap_out;

   clk_mon_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_modn (
      .i_clk   (i_user_clock),
      .i_rst_n (i_reset_n),
      .i_async (i_clk_modn),
      .o_level (w_modn_level),
      .o_rise  (w_modn_rise)
   );

   always_comb begin
      w_edgen_nxt   = r_edgen_acc;
      w_overlap_nxt = r_overlap_acc;
      if (w_modn_rise && (r_edgen_acc != '1)) w_edgen_nxt = r_edgen_acc + CNT_W'(1);
      if (w_mod_level && w_modn_level && (r_overlap_acc != '1)) begin
         w_overlap_nxt = r_overlap_acc + CNT_W'(1);
      end
   end

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_edgen_acc   <= '0;
         r_overlap_acc <= '0;
      end else if (!w_in_run || w_terminal) begin
         r_edgen_acc   <= '0;
         r_overlap_acc <= '0;
      end else begin
         r_edgen_acc   <= w_edgen_nxt;
         r_overlap_acc <= w_overlap_nxt;
      end
   end

   always_ff @(posedge i_user_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_edgen_out   <= '0;
         r_overlap_out <= '0;
      end else if (w_capture) begin
         r_edgen_out   <= w_edgen_nxt;
         r_overlap_out <= w_overlap_nxt;
      end
   end

   assign meas_if.edgen_cnt   = r_edgen_out;
   assign meas_if.overlap_cnt = r_overlap_out;
`else
   logic w_unused_modn;
   assign w_unused_modn       = i_clk_modn;
   assign meas_if.edgen_cnt   = '0;
   assign meas_if.overlap_cnt = '0;
`endif

endmodule
